// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared select encodings for the 4:1 word multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;
    localparam logic [1:0] SEL_D3 = 2'b11;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
// Module      : mux2
// Description : WIDTH-bit 2:1 multiplexer, leaf cell of the 4:1 select tree.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    // Ternary keeps an unknown select visible as X instead of defaulting to a_i.
    assign y_o = sel_i ? b_i : a_i;

endmodule : mux2
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4to1
// Description : Zero-latency 4:1 word mux with a one-cycle registered copy.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] y_d;

    mux2 #(.WIDTH(WIDTH)) u_lo (
        .a_i   (d0),
        .b_i   (d1),
        .sel_i (S[0]),
        .y_o   (w_lo)
    );

    mux2 #(.WIDTH(WIDTH)) u_hi (
        .a_i   (d2),
        .b_i   (d3),
        .sel_i (S[0]),
        .y_o   (w_hi)
    );

    mux2 #(.WIDTH(WIDTH)) u_out (
        .a_i   (w_lo),
        .b_i   (w_hi),
        .sel_i (S[1]),
        .y_o   (y_d)
    );

    // y never passes through the register, so it is valid without a clock.
    assign y = y_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

endmodule : mux_4to1
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4to1
// Description : Scoreboard bench for mux_4to1 at WIDTH = 6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4to1;
    import mux_pkg::*;

    localparam int WIDTH = 6;

    logic             clk;
    logic             clk_en;
    logic             reset;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [1:0]       S;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_v;
    int               errors;
    int               checks;

    mux_4to1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .S     (S),
        .y     (y),
        .y_q   (y_q)
    );

    // Clock is gated so the early combinational tests see no edge at all.
    always #5 clk = clk_en ? ~clk : clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WIDTH-1:0] model(input logic [1:0] s,
                                               input logic [WIDTH-1:0] a, b, c, d);
        case (s)
            SEL_D0:  return a;
            SEL_D1:  return b;
            SEL_D2:  return c;
            default: return d;
        endcase
    endfunction

    task automatic pop_check_y(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got y=%h", name, y);
        end else begin
            exp_v = exp_q.pop_front();
            if (y !== exp_v) begin
                errors++;
                $display("FAIL %s: y got %h required %h", name, y, exp_v);
            end
        end
    endtask

    task automatic pop_check_yq(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got y_q=%h", name, y_q);
        end else begin
            exp_v = exp_q.pop_front();
            if (y_q !== exp_v) begin
                errors++;
                $display("FAIL %s: y_q got %h required %h", name, y_q, exp_v);
            end
        end
    endtask

    task automatic test_comb_basic();
        logic [1:0] s;
        d0 = 6'd0; d1 = 6'd1; d2 = 6'd2; d3 = 6'd4;
        S = SEL_D0;
        exp_q.push_back(6'd0);
        #10;
        pop_check_y("comb_s00_noclk");
        checks++;
        if (clk !== 1'b0) begin
            errors++;
            $display("FAIL comb_noclk: clk got %b required 0", clk);
        end
        for (int i = 1; i < 4; i++) begin
            s = i[1:0];
            S = s;
            exp_q.push_back(model(s, d0, d1, d2, d3));
            #1;
            pop_check_y($sformatf("comb_basic_s%0d", i));
        end
    endtask

    task automatic test_comb_pattern();
        logic [1:0] s;
        d0 = 6'h3F; d1 = 6'h2A; d2 = 6'h15; d3 = 6'h00;
        for (int i = 0; i < 4; i++) begin
            s = i[1:0];
            S = s;
            exp_q.push_back(model(s, d0, d1, d2, d3));
            #1;
            pop_check_y($sformatf("comb_pattern_s%0d", i));
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        S = SEL_D3; d3 = 6'h3F;
        exp_q.push_back('0);
        @(posedge clk); #1;
        pop_check_yq("reset_yq");
        exp_q.push_back(6'h3F);
        pop_check_y("reset_y_unaffected");
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        reset = 1'b0;
        d0 = 6'h3F; d1 = 6'h2A; d2 = 6'h15; d3 = 6'h3F;
        S = SEL_D2;
        exp_q.push_back(6'h15);
        @(posedge clk); #1;
        pop_check_yq("pipe_yq_15");
        @(negedge clk);
        S = SEL_D1;
        #1;
        exp_q.push_back(6'h2A);
        pop_check_y("pipe_y_follows");
        exp_q.push_back(6'h15);
        pop_check_yq("pipe_yq_holds");
        exp_q.push_back(6'h2A);
        @(posedge clk); #1;
        pop_check_yq("pipe_yq_2a");
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back('0);
        @(posedge clk); #1;
        pop_check_yq("mid_reset_yq");
        exp_q.push_back(6'h2A);
        pop_check_y("mid_reset_y");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(6'h2A);
        @(posedge clk); #1;
        pop_check_yq("mid_resume_yq");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d0 = 6'($urandom); d1 = 6'($urandom);
            d2 = 6'($urandom); d3 = 6'($urandom);
            S  = 2'($urandom_range(0, 3));
            exp_q.push_back(model(S, d0, d1, d2, d3));
            @(posedge clk); #1;
            pop_check_yq($sformatf("b2b_%0d", i));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        reset  = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        S  = SEL_D0;

        test_comb_basic();
        test_comb_pattern();
        test_reset();
        test_pipeline();
        test_midstream_reset();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_4to1
`default_nettype wire
